// File: rtl/pm_loader_pkg.sv
// ============================================================================
// Module   : pm_loader_pkg
// Brief    : Shared types and constants for the program-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pm_loader_pkg;

    localparam int          ADDR_W        = 8;
    localparam int          DATA_W        = 8;
    localparam logic [7:0]  HDR_BYTE_DFLT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pm_loader_timer.sv
// ============================================================================
// Module   : pm_loader_timer
// Brief    : Loadable down-counter flagging a stalled byte stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pm_loader_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int          CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded with N-1 so expired is seen in the Nth idle cycle and acted on at its edge
    localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= c_LOAD;
        end else if (clear) begin
            r_cnt <= c_LOAD;
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = enable && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pm_loader.sv
// ============================================================================
// Module   : pm_loader
// Brief    : Writes a framed, checksummed byte stream into program memory and
//            holds the CPU in reset until a good frame has been loaded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] pm_wr_addr,
    output logic [DATA_W-1:0] pm_wr_data,
    output logic              pm_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   bytes_written
);

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W:0]    r_remain;
    logic [DATA_W-1:0]  r_acc;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_wren;
    logic               r_hold;
    logic               r_done;
    logic               r_err;
    logic [ADDR_W:0]    r_bytes;

    logic               w_xfer;
    logic               w_in_frame;
    logic               w_expired;
    logic               w_timeout;

    assign in_ready   = (r_state != DONE);
    assign w_xfer     = in_valid && in_ready;
    assign w_in_frame = (r_state == ADDR) || (r_state == LEN) ||
                        (r_state == DATA) || (r_state == CSUM);
    // A byte arriving in the same cycle as expiry still counts
    assign w_timeout  = w_expired && !w_xfer;

    pm_loader_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_xfer || !w_in_frame),
        .enable  (w_in_frame),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_xfer && (in_data == HDR_BYTE)) w_state_nxt = ADDR;
            ADDR: if (w_xfer) w_state_nxt = LEN;  else if (w_timeout) w_state_nxt = IDLE;
            LEN:  if (w_xfer) w_state_nxt = DATA; else if (w_timeout) w_state_nxt = IDLE;
            DATA: begin
                if (w_xfer) begin
                    if (r_remain == (ADDR_W+1)'(1)) w_state_nxt = CSUM;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            CSUM: if (w_xfer) w_state_nxt = DONE; else if (w_timeout) w_state_nxt = IDLE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_remain  <= '0;
            r_acc     <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wren    <= 1'b0;
            r_hold    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_bytes   <= '0;
        end else begin
            r_wren <= 1'b0;
            r_done <= 1'b0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_xfer && (in_data == HDR_BYTE)) begin
                        r_hold  <= 1'b1;
                        r_err   <= 1'b0;
                        r_bytes <= '0;
                        r_acc   <= '0;
                    end
                end
                ADDR: if (w_xfer) r_ptr <= in_data;
                LEN: begin
                    // A length byte of zero encodes a full 256-byte page
                    if (w_xfer) r_remain <= (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                            : {1'b0, in_data};
                end
                DATA: begin
                    if (w_xfer) begin
                        r_wren    <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_data <= in_data;
                        r_ptr     <= r_ptr + 1'b1;
                        r_acc     <= r_acc + in_data;
                        r_bytes   <= r_bytes + 1'b1;
                        r_remain  <= r_remain - 1'b1;
                    end
                end
                CSUM: begin
                    if (w_xfer) begin
                        if (in_data == r_acc) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pm_wr_addr    = r_wr_addr;
    assign pm_wr_data    = r_wr_data;
    assign pm_wren       = r_wren;
    assign cpu_hold      = r_hold;
    assign load_done     = r_done;
    assign load_err      = r_err;
    assign bytes_written = r_bytes;

endmodule

`default_nettype wire

// File: tb/tb_pm_loader.sv
// ============================================================================
// Module   : tb_pm_loader
// Brief    : Self-checking bench for pm_loader against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pm_loader;

    localparam int c_TIMEOUT = 50;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  pm_wr_addr;
    logic [7:0]  pm_wr_data;
    logic        pm_wren;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [8:0]  bytes_written;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [15:0] got_wr[$];
    logic [7:0]  payload[$];

    pm_loader #(
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .HDR_BYTE       (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pm_wr_addr    (pm_wr_addr),
        .pm_wr_data    (pm_wr_data),
        .pm_wren       (pm_wren),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_err      (load_err),
        .bytes_written (bytes_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write and pulse monitor
    always @(negedge clk) begin
        if (pm_wren === 1'b1) got_wr.push_back({pm_wr_addr, pm_wr_data});
        if (load_done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'b0, in_ready},      1);
        check({tag, "_addr"},  {24'b0, pm_wr_addr},    0);
        check({tag, "_data"},  {24'b0, pm_wr_data},    0);
        check({tag, "_wren"},  {31'b0, pm_wren},       0);
        check({tag, "_hold"},  {31'b0, cpu_hold},      0);
        check({tag, "_done"},  {31'b0, load_done},     0);
        check({tag, "_err"},   {31'b0, load_err},      0);
        check({tag, "_bytes"}, {23'b0, bytes_written}, 0);
    endtask

    // Present one byte (after an optional random gap) and return #1 after its transfer edge
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int w;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (in_ready !== 1'b1 && w < 4) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) check("ready_wait", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends garbage, then a full frame built from payload; csum_delta != 0 corrupts the checksum
    task automatic run_frame(input logic [7:0] start, input int n, input logic [7:0] csum_delta,
                             input int max_gap, input int garbage);
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] exp_a;
        int         d0;
        bit         good;
        sum  = 8'h00;
        for (int i = 0; i < n; i++) sum = sum + payload[i];
        good = (csum_delta == 8'h00);
        got_wr.delete();
        d0 = done_cnt;
        for (int i = 0; i < garbage; i++) begin
            b = 8'($urandom_range(255, 0));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, max_gap);
        end
        send_byte(8'hA5, max_gap);
        check("hold_set", {31'b0, cpu_hold}, 1);
        check("err_clr",  {31'b0, load_err}, 0);
        send_byte(start, max_gap);
        send_byte(8'(n), max_gap);
        for (int i = 0; i < n; i++) send_byte(payload[i], max_gap);
        send_byte(sum + csum_delta, max_gap);
        check("done_ready", {31'b0, in_ready},  0);
        check("done_pulse", {31'b0, load_done}, {31'b0, good});
        check("hold_end",   {31'b0, cpu_hold},  {31'b0, !good});
        check("err_end",    {31'b0, load_err},  {31'b0, !good});
        check("bytes",      {23'b0, bytes_written}, n);
        @(posedge clk);
        #1;
        check("ready_back", {31'b0, in_ready},  1);
        check("done_clr",   {31'b0, load_done}, 0);
        check("done_count", done_cnt - d0, {31'b0, good});
        check("wr_count",   got_wr.size(), n);
        for (int i = 0; i < n && i < got_wr.size(); i++) begin
            exp_a = start + 8'(i);
            check("wr", {16'b0, got_wr[i]}, {16'b0, exp_a, payload[i]});
        end
    endtask

    task automatic rand_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(255, 0)));
    endtask

    initial begin
        int          n;
        logic [7:0]  delta;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("post_rst");

        // Directed frames
        payload = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h10, 3, 8'h00, 0, 0);
        payload = '{8'h01, 8'h02, 8'h03};
        run_frame(8'hFE, 3, 8'h00, 0, 0);
        payload = '{8'h7F};
        run_frame(8'h00, 1, 8'h81, 0, 0);
        rand_payload(5);
        run_frame(8'h33, 5, 8'h00, 2, 2);

        // Timeout mid-DATA
        got_wr.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h20, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        repeat (c_TIMEOUT - 1) @(posedge clk);
        #1;
        check("to_early", {31'b0, load_err}, 0);
        @(posedge clk);
        #1;
        check("to_err",  {31'b0, load_err}, 1);
        check("to_hold", {31'b0, cpu_hold}, 1);
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        repeat (3) @(posedge clk);
        #1;
        check("to_wr_count", got_wr.size(), 1);
        check("to_wr", {16'b0, got_wr[0]}, 32'h20AA);
        check("to_err_held", {31'b0, load_err}, 1);
        rand_payload(4);
        run_frame(8'hC0, 4, 8'h00, 1, 0);

        // Full 256-byte page
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'h01);
        run_frame(8'h00, 256, 8'h00, 0, 0);

        // Randomized frames with gaps, garbage and occasional bad checksums
        for (int f = 0; f < 20; f++) begin
            n = ($urandom_range(9, 0) == 0) ? 256 : int'($urandom_range(40, 1));
            rand_payload(n);
            delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_frame(8'($urandom_range(255, 0)), n, delta, 3, int'($urandom_range(3, 0)));
        end

        // Reset mid-DATA with in_valid stuck high
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        send_byte(8'h10, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        got_wr.delete();
        check_reset_values("mid_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst_nowr", got_wr.size(), 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rel_nowr", got_wr.size(), 0);
        check_reset_values("rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
